// File: rtl/am_pkg.sv
// Shared definitions for the approximate-multiplier dot-product accumulator.
//   PROD_W  : width of one product from the 8x8 multiplier stage.
//   state_e : accumulator FSM states.
package am_pkg;

    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_e;

endpackage : am_pkg

// File: rtl/am_sat_add.sv
// Saturating unsigned adder: ACC_W-bit accumulator plus a zero-extended PROD_W-bit product.
// Ports:
//   i_acc   : current accumulator value.
//   i_add   : unsigned product to add.
//   o_sum   : i_acc + i_add, clamped to all ones on overflow.
//   o_carry : 1 when the true sum does not fit in ACC_W bits.
module am_sat_add
    import am_pkg::*;
#(
    parameter int unsigned ACC_W = 24
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_add,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    // One extra bit catches the carry out of the accumulator width.
    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_add};
    assign o_carry = w_full[ACC_W];
    assign o_sum   = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule : am_sat_add

// File: rtl/am_dot_acc.sv
// Dot-product / tap-sum accumulator on the multiplier's product stream.
// Sums up to LEN unsigned products (or fewer when i_prod_last ends the group) into a
// saturating ACC_W-bit value and presents the result on a valid/ready port.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset.
//   i_prod_valid/i_prod_data/i_prod_last, o_prod_ready : product input stream.
//   o_out_valid/i_out_ready          : result handshake.
//   o_out_data                       : saturated group sum.
//   o_out_count                      : number of products in the group.
//   o_out_ovf                        : saturation happened within the group.
module am_dot_acc
    import am_pkg::*;
#(
    parameter int unsigned LEN   = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_prod_valid,
    input  logic [PROD_W-1:0] i_prod_data,
    input  logic              i_prod_last,
    output logic              o_prod_ready,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ACC_W-1:0]  o_out_data,
    output logic [7:0]        o_out_count,
    output logic              o_out_ovf
);

    localparam logic [7:0] LenCnt = 8'(LEN);

    state_e           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;
    logic             r_prod_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic [7:0]       w_cnt_inc;
    logic             w_end_beat;

    assign w_accept   = i_prod_valid & r_prod_ready;
    assign w_cnt_inc  = r_cnt + 8'd1;
    // Covers both a full group and an early end; a last beat that also fills the group
    // ends it just once.
    assign w_end_beat = (w_cnt_inc == LenCnt) | i_prod_last;

    // In StIdle the accumulator is zero, so the same adder yields the plain first product.
    am_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_acc   (r_acc),
        .i_add   (i_prod_data),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_prod_ready <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StAccum: begin
                    r_prod_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_inc;
                        r_ovf <= r_ovf | w_carry;
                        if (w_end_beat) begin
                            r_state      <= StHold;
                            r_prod_ready <= 1'b0;
                            r_out_valid  <= 1'b1;
                        end else begin
                            r_state <= StAccum;
                        end
                    end
                end
                StHold: begin
                    if (i_out_ready) begin
                        r_state      <= StIdle;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_ovf        <= 1'b0;
                        r_prod_ready <= 1'b1;
                        r_out_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_acc        <= '0;
                    r_cnt        <= '0;
                    r_ovf        <= 1'b0;
                    r_prod_ready <= 1'b1;
                    r_out_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign o_prod_ready = r_prod_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_acc;
    assign o_out_count  = r_cnt;
    assign o_out_ovf    = r_ovf;

endmodule : am_dot_acc

// File: tb/tb_am_dot_acc.sv
// Directed bench for am_dot_acc: instance A (LEN=4, ACC_W=16) and instance B (LEN=3, ACC_W=24).
module tb_am_dot_acc;

    logic clk;
    logic rst_n;

    logic        a_valid, a_last, a_oready, a_pready, a_ovalid, a_ovf;
    logic [15:0] a_data, a_odata;
    logic [7:0]  a_ocount;

    logic        b_valid, b_last, b_oready, b_pready, b_ovalid, b_ovf;
    logic [15:0] b_data;
    logic [23:0] b_odata;
    logic [7:0]  b_ocount;

    int n_chk;
    int n_err;

    am_dot_acc #(
        .LEN   (4),
        .ACC_W (16)
    ) u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_prod_valid (a_valid),
        .i_prod_data  (a_data),
        .i_prod_last  (a_last),
        .o_prod_ready (a_pready),
        .o_out_valid  (a_ovalid),
        .i_out_ready  (a_oready),
        .o_out_data   (a_odata),
        .o_out_count  (a_ocount),
        .o_out_ovf    (a_ovf)
    );

    am_dot_acc #(
        .LEN   (3),
        .ACC_W (24)
    ) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_prod_valid (b_valid),
        .i_prod_data  (b_data),
        .i_prod_last  (b_last),
        .o_prod_ready (b_pready),
        .o_out_valid  (b_ovalid),
        .i_out_ready  (b_oready),
        .o_out_data   (b_odata),
        .o_out_count  (b_ocount),
        .o_out_ovf    (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_out(input string tag, input logic [15:0] d, input logic [7:0] c,
                             input logic o);
        chk({tag, "_valid"}, 32'(a_ovalid), 32'd1);
        chk({tag, "_pready"}, 32'(a_pready), 32'd0);
        chk({tag, "_data"}, 32'(a_odata), 32'(d));
        chk({tag, "_count"}, 32'(a_ocount), 32'(c));
        chk({tag, "_ovf"}, 32'(a_ovf), 32'(o));
    endtask

    task automatic a_beat(input logic [15:0] d, input logic l);
        a_valid = 1'b1;
        a_data  = d;
        a_last  = l;
        tick();
    endtask

    task automatic a_idle();
        a_valid = 1'b0;
        a_last  = 1'b0;
        tick();
        chk("a_back_to_idle_valid", 32'(a_ovalid), 32'd0);
        chk("a_back_to_idle_pready", 32'(a_pready), 32'd1);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        a_valid  = 1'b0; a_last = 1'b0; a_data = '0; a_oready = 1'b1;
        b_valid  = 1'b0; b_last = 1'b0; b_data = '0; b_oready = 1'b1;

        // Reset state
        #3;
        chk("rst_pready", 32'(a_pready), 32'd0);
        chk("rst_valid", 32'(a_ovalid), 32'd0);
        chk("rst_data", 32'(a_odata), 32'd0);
        chk("rst_count", 32'(a_ocount), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        tick();
        tick();
        chk("rst_hold_pready", 32'(a_pready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_pready", 32'(a_pready), 32'd1);
        chk("rel_b_pready", 32'(b_pready), 32'd1);

        // Full group of LEN products
        a_beat(16'd1000, 1'b0);
        chk("full_mid_valid", 32'(a_ovalid), 32'd0);
        chk("full_mid_pready", 32'(a_pready), 32'd1);
        a_beat(16'd2000, 1'b0);
        a_beat(16'd3000, 1'b0);
        a_beat(16'd4000, 1'b0);
        chk_a_out("full", 16'd10000, 8'd4, 1'b0);
        a_idle();

        // Early end via prod_last
        a_beat(16'd500, 1'b0);
        a_beat(16'd700, 1'b1);
        chk_a_out("early", 16'd1200, 8'd2, 1'b0);
        a_idle();

        // Next group starts from zero; prod_last coinciding with cnt==LEN
        a_beat(16'd1, 1'b0);
        a_beat(16'd1, 1'b0);
        a_beat(16'd1, 1'b0);
        a_beat(16'd1, 1'b1);
        chk_a_out("last_at_len", 16'd4, 8'd4, 1'b0);
        a_idle();

        // Saturation
        a_beat(16'hFFF0, 1'b0);
        a_beat(16'h0020, 1'b0);
        a_beat(16'h0005, 1'b1);
        chk_a_out("sat", 16'hFFFF, 8'd3, 1'b1);
        a_idle();
        chk("sat_ovf_cleared", 32'(a_ovf), 32'd0);

        // Back-pressure in HOLD
        a_beat(16'h0011, 1'b1);
        chk_a_out("bp_enter", 16'h0011, 8'd1, 1'b0);
        a_oready = 1'b0;
        a_valid  = 1'b1;
        a_data   = 16'h1234;
        a_last   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a_out("bp_stall", 16'h0011, 8'd1, 1'b0);
        end
        a_oready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(a_ovalid), 32'd0);
        chk("bp_release_pready", 32'(a_pready), 32'd1);
        chk("bp_release_count", 32'(a_ocount), 32'd0);
        tick();
        a_beat(16'h0001, 1'b1);
        chk_a_out("bp_next", 16'h1235, 8'd2, 1'b0);
        a_idle();

        // Asynchronous reset mid-group
        a_beat(16'd100, 1'b0);
        a_beat(16'd200, 1'b0);
        a_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_data", 32'(a_odata), 32'd0);
        chk("mrst_count", 32'(a_ocount), 32'd0);
        chk("mrst_pready", 32'(a_pready), 32'd0);
        chk("mrst_valid", 32'(a_ovalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mrst_rel_pready", 32'(a_pready), 32'd1);
        chk("mrst_rel_valid", 32'(a_ovalid), 32'd0);
        a_beat(16'd7, 1'b1);
        chk_a_out("mrst_new", 16'd7, 8'd1, 1'b0);
        a_idle();

        // Bubbles on instance B (LEN=3)
        b_valid = 1'b1; b_data = 16'd10; tick();
        b_valid = 1'b0; tick(); tick();
        chk("bub_mid_valid", 32'(b_ovalid), 32'd0);
        chk("bub_mid_pready", 32'(b_pready), 32'd1);
        b_valid = 1'b1; b_data = 16'd20; tick();
        b_valid = 1'b0; tick(); tick();
        chk("bub_mid2_valid", 32'(b_ovalid), 32'd0);
        b_valid = 1'b1; b_data = 16'd30; tick();
        b_valid = 1'b0;
        chk("bub_valid", 32'(b_ovalid), 32'd1);
        chk("bub_pready", 32'(b_pready), 32'd0);
        chk("bub_data", 32'(b_odata), 32'd60);
        chk("bub_count", 32'(b_ocount), 32'd3);
        chk("bub_ovf", 32'(b_ovf), 32'd0);
        tick();
        chk("bub_done_valid", 32'(b_ovalid), 32'd0);
        chk("bub_done_pready", 32'(b_pready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_am_dot_acc
